// File: rtl/wisard_bleach_argmax.sv
// wisard_bleach_argmax: bleached WiSARD score accumulation with sequential argmax
module wisard_bleach_argmax #(
  parameter int N_CLASSES   = 10,
  parameter int CLASS_WIDTH = 4,
  parameter int N_RAMS      = 56,
  parameter int VAL_WIDTH   = 8,
  parameter int SCORE_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VAL_WIDTH-1:0]           bleach,
  input  logic                           sink_valid,
  output logic                           sink_ready,
  input  logic                           sink_sop,
  input  logic                           sink_eop,
  input  logic [N_CLASSES*VAL_WIDTH-1:0] sink_data,
  output logic                           source_valid,
  input  logic                           source_ready,
  output logic [CLASS_WIDTH-1:0]         predicted_class,
  output logic [SCORE_WIDTH-1:0]         best_score,
  output logic [SCORE_WIDTH-1:0]         margin,
  output logic                           tie,
  output logic                           frame_err
);
  localparam int IW = $clog2(N_CLASSES + 1);
  localparam int CW = $clog2(N_RAMS + 2);
  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, HOLD} state_t;
  state_t state, state_n;
  logic [VAL_WIDTH-1:0] bleach_q, thr;
  logic [SCORE_WIDTH-1:0] score [N_CLASSES];
  logic [SCORE_WIDTH-1:0] best, second, cur;
  logic [N_CLASSES-1:0] hit;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [CLASS_WIDTH-1:0] best_idx;
  logic err, sticky, acc, start, proc, scan_done;
  assign sink_ready = state == IDLE || state == ACCUM;
  assign source_valid = state == HOLD;
  assign acc = sink_valid && sink_ready;
  assign start = acc && sink_sop;
  assign proc = start || (acc && state == ACCUM);
  assign thr = start ? bleach : bleach_q;
  assign scan_done = idx == IW'(N_CLASSES);
  // sop beats compare against the threshold arriving with them
  always_comb begin
    cur = '0;
    hit = '0;
    for (int c = 0; c < N_CLASSES; c++) begin
      hit[c] = sink_data[c*VAL_WIDTH +: VAL_WIDTH] >= thr;
      if (idx == IW'(c)) cur = score[c];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (sink_eop ? ARGMAX : ACCUM) : IDLE;
      ACCUM:   state_n = acc && sink_eop ? ARGMAX : ACCUM;
      ARGMAX:  state_n = scan_done ? HOLD : ARGMAX;
      HOLD:    state_n = source_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bleach_q        <= '0;
      cnt             <= '0;
      err             <= 1'b0;
      sticky          <= 1'b0;
      idx             <= '0;
      best            <= '0;
      second          <= '0;
      best_idx        <= '0;
      predicted_class <= '0;
      best_score      <= '0;
      margin          <= '0;
      tie             <= 1'b0;
      frame_err       <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) score[c] <= '0;
    end else begin
      if (start) begin
        bleach_q <= bleach;
        err      <= state == ACCUM || sticky;
      end
      sticky <= start ? 1'b0 : (acc && state == IDLE) ? 1'b1 : sticky;
      if (proc) begin
        cnt <= start ? CW'(1) : cnt + CW'(cnt != '1);
        for (int c = 0; c < N_CLASSES; c++)
          score[c] <= start ? SCORE_WIDTH'(hit[c]) : score[c] + SCORE_WIDTH'(hit[c] && score[c] != '1);
      end
      // strict > keeps the lowest index on ties
      if (state != ARGMAX) begin
        idx      <= '0;
        best     <= '0;
        second   <= '0;
        best_idx <= '0;
      end else if (!scan_done) begin
        idx <= idx + 1'b1;
        if (cur > best) begin
          best     <= cur;
          second   <= best;
          best_idx <= CLASS_WIDTH'(idx);
        end else if (cur > second) second <= cur;
      end else begin
        predicted_class <= best_idx;
        best_score      <= best;
        margin          <= best - second;
        tie             <= best == second;
        frame_err       <= err || cnt != CW'(N_RAMS);
      end
    end
endmodule

// File: tb/tb_wisard_bleach_argmax.sv
// tb_wisard_bleach_argmax: scoreboard bench with directed frames and hand-computed results
module tb_wisard_bleach_argmax;
  typedef struct packed {
    logic [3:0] cls;
    logic [5:0] best;
    logic [5:0] marg;
    logic       tie;
    logic       err;
  } res_t;
  logic clk = 0, rst = 1;
  logic [7:0] bleach = 0;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0, source_ready = 1;
  logic [79:0] sink_data = 0;
  logic sink_ready, source_valid, tie, frame_err;
  logic [3:0] predicted_class;
  logic [5:0] best_score, margin;
  res_t q[$];
  int vectors = 0, errs = 0;
  int n;
  always #5 clk = ~clk;
  wisard_bleach_argmax dut (
    .clk(clk), .rst(rst), .bleach(bleach), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_data(sink_data), .source_valid(source_valid),
    .source_ready(source_ready), .predicted_class(predicted_class), .best_score(best_score),
    .margin(margin), .tie(tie), .frame_err(frame_err)
  );
  always @(negedge clk)
    if (!rst && source_valid && source_ready) begin
      res_t g, e;
      g = '{predicted_class, best_score, margin, tie, frame_err};
      vectors++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_result got cls=%0d best=%0d margin=%0d tie=%0b err=%0b", g.cls, g.best, g.marg, g.tie, g.err);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          errs++;
          $display("FAIL result got cls=%0d best=%0d margin=%0d tie=%0b err=%0b required cls=%0d best=%0d margin=%0d tie=%0b err=%0b",
                   g.cls, g.best, g.marg, g.tie, g.err, e.cls, e.best, e.marg, e.tie, e.err);
        end
      end
    end
  function automatic logic [79:0] beat_data(int pat, int k);
    logic [79:0] d;
    logic [7:0] v;
    d = '0;
    for (int c = 0; c < 10; c++) begin
      case (pat)
        1: v = c == 3 ? 8'd5 : 8'd1;
        2: v = (c == 4 || c == 7) ? 8'(k < 30) : 8'(k < c);
        3: v = 8'(c);
        4: v = 8'(c == 1);
        5: v = 8'(c == 0);
        6: v = c == 2 ? 8'd7 : c == 6 ? 8'd9 : 8'd0;
        default: v = 8'd0;
      endcase
      d[c*8 +: 8] = v;
    end
    return d;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask
  task automatic push(input int cls, input int best, input int marg, input int t, input int e);
    q.push_back('{4'(cls), 6'(best), 6'(marg), 1'(t), 1'(e)});
  endtask
  task automatic send(input logic [7:0] b, input int nb, input int pat, input logic sop, input logic eop);
    int t;
    for (int k = 0; k < nb; k++) begin
      t = 0;
      while (!sink_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (!sink_ready) begin
        vectors++;
        errs++;
        $display("FAIL sink_ready_timeout got 0 required 1");
      end
      sink_valid = 1;
      sink_sop = sop && k == 0;
      sink_eop = eop && k == nb - 1;
      bleach = b;
      sink_data = beat_data(pat, k);
      @(posedge clk); #1;
    end
    sink_valid = 0;
    sink_sop = 0;
    sink_eop = 0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!source_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!source_valid) begin
      vectors++;
      errs++;
      $display("FAIL valid_timeout got 0 required 1");
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({source_valid, sink_ready, predicted_class, best_score, margin, tie, frame_err}), 32'h40000);
    rst = 0;
    push(0, 56, 0, 1, 0);
    send(0, 56, 0, 1, 1);
    push(3, 56, 56, 0, 0);
    send(2, 56, 1, 1, 1);
    wait_valid(n);
    chk("latency", 32'(n), 32'd11);
    push(4, 30, 0, 1, 0);
    send(1, 56, 2, 1, 1);
    wait_valid(n);
    @(posedge clk); #1;
    source_ready = 0;
    push(9, 56, 56, 0, 0);
    send(9, 56, 3, 1, 1);
    wait_valid(n);
    repeat (20) begin
      @(posedge clk); #1;
      chk("hold_stable", 32'({source_valid, sink_ready, predicted_class, best_score, margin, tie, frame_err}),
          32'({1'b1, 1'b0, 4'd9, 6'd56, 6'd56, 1'b0, 1'b0}));
    end
    source_ready = 1;
    @(posedge clk); #1;
    chk("release", 32'({source_valid, sink_ready}), 32'b01);
    push(1, 56, 56, 0, 1);
    send(1, 10, 5, 1, 0);
    send(1, 56, 4, 1, 1);
    push(0, 55, 0, 1, 1);
    send(0, 55, 0, 1, 1);
    push(1, 56, 56, 0, 1);
    send(0, 1, 0, 0, 0);
    send(1, 56, 4, 1, 1);
    push(2, 1, 0, 1, 1);
    send(5, 1, 6, 1, 1);
    push(0, 63, 0, 1, 1);
    send(0, 70, 0, 1, 1);
    send(2, 56, 1, 1, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst = 1;
    #1 chk("rst_async", 32'({source_valid, sink_ready}), 32'b01);
    #2 rst = 0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("no_result_after_rst", 32'(source_valid), 32'd0);
    push(3, 56, 56, 0, 0);
    send(2, 56, 1, 1, 1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
